par_arb_mux_s2m: RTL

- Parametrised, arbitrated slave-to-master response channel multiplexer for the AXI interconnect.
- Replaces one-hot-select READY muxing with a full channel mux: it arbitrates among SlaveCount slaves (round-robin) and forwards VALID/DATA/ID/RESP/LAST to one master.
- Routes the master's READY back to the granted slave only.
- Holds the grant until the burst's LAST beat handshakes, so bursts never interleave. Sits between the slave R (or B) channels and one master port.

---
 rtl/par_arb_mux_s2m_if.sv | 43 ++++
 rtl/par_arb_mux_s2m.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/par_arb_mux_s2m_if.sv
// par_arb_mux_s2m_if -- bundle of the slave-to-master response channel signals
// seen by par_arb_mux_s2m.
//   slave  : the multiplexer's view (consumes slave VALID/LAST/DATA/ID/RESP and
//            master READY, produces master-side channel plus per-slave READY).
//   master : the environment's view (drives slave channels and master READY,
//            observes the muxed channel, READYs and status).
interface par_arb_mux_s2m_if #(
  parameter int SlaveCount = 6,
  parameter int DataWidth  = 32,
  parameter int IdWidth    = 8,
  parameter int RespWidth  = 2
);
  // Slave-side inputs to the mux (packed, slave i at [i*W +: W])
  logic [SlaveCount-1:0]           VALIDs_in;
  logic [SlaveCount-1:0]           LASTs_in;
  logic [SlaveCount*DataWidth-1:0] DATAs_in;
  logic [SlaveCount*IdWidth-1:0]   IDs_in;
  logic [SlaveCount*RespWidth-1:0] RESPs_in;
  // Master READY into the mux
  logic                            READY_in;
  // Master-side outputs of the mux
  logic                            VALID_out;
  logic [DataWidth-1:0]            DATA_out;
  logic [IdWidth-1:0]              ID_out;
  logic [RespWidth-1:0]            RESP_out;
  logic                            LAST_out;
  // Per-slave READY return and status
  logic [SlaveCount-1:0]           READYs_out;
  logic [SlaveCount-1:0]           grant_out;
  logic                            busy_out;

  modport slave (
    input  VALIDs_in, LASTs_in, DATAs_in, IDs_in, RESPs_in, READY_in,
    output VALID_out, DATA_out, ID_out, RESP_out, LAST_out,
    output READYs_out, grant_out, busy_out
  );

  modport master (
    output VALIDs_in, LASTs_in, DATAs_in, IDs_in, RESPs_in, READY_in,
    input  VALID_out, DATA_out, ID_out, RESP_out, LAST_out,
    input  READYs_out, grant_out, busy_out
  );
endinterface

// File: rtl/par_arb_mux_s2m.sv
// par_arb_mux_s2m -- arbitrated slave-to-master response channel multiplexer.
// Picks one of SlaveCount slaves (round-robin by default), forwards its
// VALID/DATA/ID/RESP/LAST to the master with zero latency, returns the master
// READY to the granted slave only, and locks the grant until the LAST beat of
// the burst handshakes so bursts never interleave.
//
// Build option: define PAR_ARB_MUX_S2M_FIXED_PRIO_EN to replace the
// round-robin pick with fixed lowest-index-first priority (no pointer state).
module par_arb_mux_s2m #(
  parameter int SlaveCount = 6,
  parameter int DataWidth  = 32,
  parameter int IdWidth    = 8,
  parameter int RespWidth  = 2
) (
  input  logic              clk,
  input  logic              rst,
  par_arb_mux_s2m_if.slave  bus
);

  localparam int PtrWidth = (SlaveCount > 1) ? $clog2(SlaveCount) : 1;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [SlaveCount-1:0] grant_q, grant_d;

  // Unpacked per-slave views of the packed payload buses
  logic [DataWidth-1:0]  data_arr [SlaveCount];
  logic [IdWidth-1:0]    id_arr   [SlaveCount];
  logic [RespWidth-1:0]  resp_arr [SlaveCount];

  // Arbitration results and effective grant
  logic [SlaveCount-1:0] pick_oh;
  logic [SlaveCount-1:0] eff_grant;

  // Muxed channel
  logic                  valid_mux;
  logic                  last_mux;
  logic [DataWidth-1:0]  data_mux;
  logic [IdWidth-1:0]    id_mux;
  logic [RespWidth-1:0]  resp_mux;
  logic                  hs;
  logic                  burst_end;

  genvar gi;
  generate
    for (gi = 0; gi < SlaveCount; gi++) begin : g_unpack
      assign data_arr[gi] = bus.DATAs_in[gi*DataWidth +: DataWidth];
      assign id_arr[gi]   = bus.IDs_in[gi*IdWidth +: IdWidth];
      assign resp_arr[gi] = bus.RESPs_in[gi*RespWidth +: RespWidth];
    end
  endgenerate

`ifdef PAR_ARB_MUX_S2M_FIXED_PRIO_EN

  // Fixed-priority pick: lowest-indexed VALID slave wins
  always_comb begin
    logic found;
    pick_oh = '0;
    found   = 1'b0;
    for (int i = 0; i < SlaveCount; i++) begin
      if (!found && bus.VALIDs_in[i]) begin
        found      = 1'b1;
        pick_oh[i] = 1'b1;
      end
    end
  end

`else

  // Round-robin pointer: index of the slave that last completed a burst
  logic [PtrWidth-1:0]   ptr_q, ptr_d;
  logic [PtrWidth-1:0]   pick_idx;
  logic [PtrWidth-1:0]   grant_idx;

  // Round-robin pick: search from ptr+1 upward, wrapping at SlaveCount
  always_comb begin
    logic                found;
    int                  cand;
    logic [PtrWidth-1:0] cidx;
    pick_oh  = '0;
    pick_idx = '0;
    found    = 1'b0;
    cand     = 0;
    cidx     = '0;
    for (int off = 1; off <= SlaveCount; off++) begin
      cand = int'(ptr_q) + off;
      if (cand >= SlaveCount) begin
        cand = cand - SlaveCount;
      end
      cidx = cand[PtrWidth-1:0];
      if (!found && bus.VALIDs_in[cidx]) begin
        found         = 1'b1;
        pick_oh[cidx] = 1'b1;
        pick_idx      = cidx;
      end
    end
  end

  // Encode the locked one-hot grant back to an index for the pointer update
  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < SlaveCount; i++) begin
      if (grant_q[i]) begin
        grant_idx = grant_idx | PtrWidth'(i);
      end
    end
  end

  // Pointer advances only when a burst finishes (single beat or LOCKED end)
  always_comb begin
    ptr_d = ptr_q;
    if (burst_end) begin
      ptr_d = (state_q == LOCKED) ? grant_idx : pick_idx;
    end
  end

  // Pointer register; reset value makes slave 0 the first searched
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= PtrWidth'(SlaveCount - 1);
    end else begin
      ptr_q <= ptr_d;
    end
  end

`endif

  // Effective grant: live pick in IDLE, held grant in LOCKED, none in reset
  always_comb begin
    eff_grant = '0;
    if (!rst) begin
      eff_grant = (state_q == LOCKED) ? grant_q : pick_oh;
    end
  end

  // AND-OR channel mux; everything reads zero when nothing is granted
  always_comb begin
    valid_mux = 1'b0;
    last_mux  = 1'b0;
    data_mux  = '0;
    id_mux    = '0;
    resp_mux  = '0;
    for (int i = 0; i < SlaveCount; i++) begin
      if (eff_grant[i]) begin
        valid_mux = valid_mux | bus.VALIDs_in[i];
        last_mux  = last_mux  | bus.LASTs_in[i];
        data_mux  = data_mux  | data_arr[i];
        id_mux    = id_mux    | id_arr[i];
        resp_mux  = resp_mux  | resp_arr[i];
      end
    end
  end

  assign hs        = valid_mux & bus.READY_in;
  assign burst_end = hs & last_mux;

  // Lock FSM next state: lock on any non-final grant, release on LAST handshake
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    case (state_q)
      IDLE: begin
        if (|eff_grant && !burst_end) begin
          grant_d = eff_grant;
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (burst_end) begin
          grant_d = '0;
          state_d = IDLE;
        end
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Lock FSM state register; reset abandons any burst in progress
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
    end
  end

  assign bus.VALID_out  = valid_mux;
  assign bus.LAST_out   = last_mux;
  assign bus.DATA_out   = data_mux;
  assign bus.ID_out     = id_mux;
  assign bus.RESP_out   = resp_mux;
  assign bus.READYs_out = eff_grant & {SlaveCount{bus.READY_in}};
  assign bus.grant_out  = eff_grant;
  assign bus.busy_out   = (state_q == LOCKED) && !rst;

endmodule
